// File: rtl/mont_redc_seq64.sv
// mont_redc_seq64: controller that computes one 64-bit Montgomery product
// result = a*b*2^-64 mod n. It issues T = a*b, m = T*n' mod 2^64 and m*n in
// turn to an external pipelined 64x64->128 multiplier, then applies the final
// conditional subtraction.
module mont_redc_seq64 #(
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [63:0]   a,
    input  logic [63:0]   b,
    input  logic [63:0]   n,
    input  logic [63:0]   n_prime,
    output logic [63:0]   result,
    output logic          done,
    output logic [63:0]   mul_a,
    output logic [63:0]   mul_b,
    input  logic [127:0]  mul_p
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_T,
        S_WAIT_M,
        S_WAIT_U,
        S_CORR
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [63:0]     r_n;
    logic [63:0]     r_n_prime;
    logic [127:0]    r_t;
    logic [64:0]     r_u;
    logic [63:0]     r_result;
    logic            r_done;
    logic            r_ready;
    logic [63:0]     r_mul_a;
    logic [63:0]     r_mul_b;

    logic [128:0]    w_sum;
    logic [64:0]     w_diff;
    logic            w_u_ge_n;
    logic            w_cnt_zero;

    // S = T + m*n keeps its carry; the low 64 bits cancel for a correct n'.
    assign w_sum      = {1'b0, r_t} + {1'b0, mul_p};
    // u < 2n, so one subtraction fully reduces it into [0, n).
    assign w_u_ge_n   = (r_u >= {1'b0, r_n});
    assign w_diff     = r_u - {1'b0, r_n};
    assign w_cnt_zero = (r_cnt == '0);

    // Sequencer: operand issue, pipeline wait, product capture and correction.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, matching the cycle-level timing diagram.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_n       <= '0;
            r_n_prime <= '0;
            r_t       <= '0;
            r_u       <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n       <= n;
                        r_n_prime <= n_prime;
                        r_mul_a   <= a;
                        r_mul_b   <= b;
                        r_cnt     <= CW'(MUL_LAT);
                        r_ready   <= 1'b0;
                        r_state   <= S_WAIT_T;
                    end
                end
                S_WAIT_T: begin
                    if (w_cnt_zero) begin
                        r_t     <= mul_p;
                        r_mul_a <= mul_p[63:0];
                        r_mul_b <= r_n_prime;
                        r_cnt   <= CW'(MUL_LAT);
                        r_state <= S_WAIT_M;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WAIT_M: begin
                    // m = T*n' mod 2^64; it lives in mul_a for the next product.
                    if (w_cnt_zero) begin
                        r_mul_a <= mul_p[63:0];
                        r_mul_b <= r_n;
                        r_cnt   <= CW'(MUL_LAT);
                        r_state <= S_WAIT_U;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WAIT_U: begin
                    if (w_cnt_zero) begin
                        r_u     <= w_sum[128:64];
                        r_state <= S_CORR;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_CORR: begin
                    r_result <= w_u_ge_n ? w_diff[63:0] : r_u[63:0];
                    r_done   <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign result = r_result;
    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;

endmodule
